uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver. It is the downstream partner of the existing 8N1 transmitter: it consumes the Tx line, either through loopback or from an external pin.
- It oversamples the line using a clock-enable pulse from the shared baud generator at OSR times the bit rate, recovers 8N1 frames LSB-first, and presents each byte with a sticky ready flag that the consumer clears.
- Adds framing-error and overrun detection and a busy indicator.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_if.sv | 29 ++
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_receiver.sv | 136 +++++++++++++
 tb/tb_uart_receiver.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding and default oversampling ratio.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Encoding is shared with the transmitter so both ends decode the same way.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int c_OSR_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/uart_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_if
// Description : Receiver line, oversample tick and consumer handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_if;

    logic       clken;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    modport master (
        output clken, rx, rdy_clr,
        input  data_out, rdy, frame_err, overrun, rx_busy
    );

    modport slave (
        input  clken, rx, rdy_clr,
        output data_out, rdy, frame_err, overrun, rx_busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchroniser for an asynchronous input; resets to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    // Reset value of 1 matches an idle serial line, so no false start on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Oversampling 8N1 UART receiver with ready, framing and overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OSR   = c_OSR_DEFAULT,
    parameter int CNT_W = 4
) (
    input  wire logic clk_50m,
    input  wire logic rst,
    uart_if.slave     bus
);

    localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_M1 = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic             w_rx_s;
    uart_state_t      r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_sample,    w_sample_nxt;
    logic [2:0]       r_bit_pos,   w_bit_pos_nxt;
    logic [7:0]       r_scratch,   w_scratch_nxt;
    logic [7:0]       r_data_out,  w_data_out_nxt;
    logic             r_rdy,       w_rdy_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_overrun,   w_overrun_nxt;

    uart_sync2 u_sync (
        .clk (clk_50m),
        .rst (rst),
        .i_d (bus.rx),
        .o_q (w_rx_s)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_sample_nxt    = r_sample;
        w_bit_pos_nxt   = r_bit_pos;
        w_scratch_nxt   = r_scratch;
        w_data_out_nxt  = r_data_out;
        w_rdy_nxt       = r_rdy;
        w_frame_err_nxt = r_frame_err;
        w_overrun_nxt   = r_overrun;

        if (bus.rdy_clr) begin
            w_rdy_nxt     = 1'b0;
            w_overrun_nxt = 1'b0;
        end

        if (bus.clken) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt  = START;
                        w_sample_nxt = c_ONE;
                    end
                end
                START: begin
                    if (r_sample == c_HALF_M1) begin
                        w_sample_nxt = '0;
                        if (!w_rx_s) begin
                            w_state_nxt   = DATA;
                            w_bit_pos_nxt = 3'd0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_sample_nxt = r_sample + c_ONE;
                    end
                end
                DATA: begin
                    if (r_sample == c_FULL_M1) begin
                        w_scratch_nxt[r_bit_pos] = w_rx_s;
                        w_sample_nxt             = '0;
                        w_bit_pos_nxt            = r_bit_pos + 3'd1;
                        if (r_bit_pos == 3'd7) begin
                            w_state_nxt = STOP;
                        end
                    end else begin
                        w_sample_nxt = r_sample + c_ONE;
                    end
                end
                STOP: begin
                    if (r_sample == c_FULL_M1) begin
                        w_data_out_nxt  = r_scratch;
                        w_frame_err_nxt = ~w_rx_s;
                        w_rdy_nxt       = 1'b1;
                        // An acknowledge in the same cycle consumes the old byte.
                        w_overrun_nxt   = bus.rdy_clr ? 1'b0 : (r_overrun | r_rdy);
                        w_state_nxt     = IDLE;
                        w_sample_nxt    = '0;
                    end else begin
                        w_sample_nxt = r_sample + c_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sample    <= '0;
            r_bit_pos   <= 3'd0;
            r_scratch   <= 8'h00;
            r_data_out  <= 8'h00;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sample    <= w_sample_nxt;
            r_bit_pos   <= w_bit_pos_nxt;
            r_scratch   <= w_scratch_nxt;
            r_data_out  <= w_data_out_nxt;
            r_rdy       <= w_rdy_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.rdy       = r_rdy;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.rx_busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed and randomised frames against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int OSR     = 16;
    localparam int DIV     = 4;
    localparam int BIT_CYC = OSR * DIV;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;

    uart_if u_bus ();

    uart_receiver #(.OSR(OSR), .CNT_W(4)) u_dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (u_bus.slave)
    );

    always #10 clk_50m = ~clk_50m;

    // Shared divider: one clken every DIV cycles.
    initial begin
        u_bus.clken = 1'b0;
        forever begin
            repeat (DIV - 1) @(negedge clk_50m);
            u_bus.clken = 1'b1;
            @(negedge clk_50m);
            u_bus.clken = 1'b0;
        end
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] m_data   = 8'h00;
    logic       m_rdy    = 1'b0;
    logic       m_ferr   = 1'b0;
    logic       m_ovr    = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "/data_out"},  u_bus.data_out,        m_data);
        check({tag, "/rdy"},       8'(u_bus.rdy),         8'(m_rdy));
        check({tag, "/frame_err"}, 8'(u_bus.frame_err),   8'(m_ferr));
        check({tag, "/overrun"},   8'(u_bus.overrun),     8'(m_ovr));
        check({tag, "/rx_busy"},   8'(u_bus.rx_busy),     8'd0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    // Byte-level model update: what the consumer sees once a frame lands.
    task automatic model_byte(input logic [7:0] b, input logic stop_low);
        m_ovr  = m_ovr | m_rdy;
        m_rdy  = 1'b1;
        m_data = b;
        m_ferr = stop_low;
    endtask

    task automatic ack();
        u_bus.rdy_clr = 1'b1;
        @(negedge clk_50m);
        u_bus.rdy_clr = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        wait_cyc(2);
    endtask

    // A low stop bit is held for 3/4 of a bit so the immediate restart is rejected
    // as a false start, leaving the line idle afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_low);
        u_bus.rx = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            u_bus.rx = b[i];
            if (i == 4) begin
                wait_cyc(BIT_CYC / 2);
                check("busy_mid_frame", 8'(u_bus.rx_busy), 8'd1);
                wait_cyc(BIT_CYC / 2);
            end else begin
                wait_cyc(BIT_CYC);
            end
        end
        if (stop_low) begin
            u_bus.rx = 1'b0;
            wait_cyc(BIT_CYC * 3 / 4);
            u_bus.rx = 1'b1;
            wait_cyc(BIT_CYC / 4);
        end else begin
            u_bus.rx = 1'b1;
            wait_cyc(BIT_CYC);
        end
        wait_cyc(BIT_CYC);
        model_byte(b, stop_low);
    endtask

    // Transmitter-style sender stepping one bit per OSR clken ticks.
    task automatic tx_loopback(input logic [7:0] b);
        logic [9:0] fr;
        int         n;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            u_bus.rx = fr[i];
            n = 0;
            while (n < OSR) begin
                @(posedge clk_50m);
                if (u_bus.clken) n = n + 1;
            end
            #1;
        end
        wait_cyc(BIT_CYC);
        model_byte(b, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;

        u_bus.rx      = 1'b1;
        u_bus.rdy_clr = 1'b0;
        wait_cyc(4);
        check_all("reset");
        rst = 1'b0;
        wait_cyc(8);

        send_frame(8'hA5, 1'b0);
        check_all("a5");
        ack();
        check_all("a5_clr");

        send_frame(8'h00, 1'b0);
        check_all("b2b_00");
        send_frame(8'hFF, 1'b0);
        check_all("b2b_ff");
        ack();
        check_all("b2b_clr");

        u_bus.rx = 1'b0;
        wait_cyc(5 * DIV);
        u_bus.rx = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check_all("glitch");

        send_frame(8'h3C, 1'b1);
        check_all("ferr_3c");
        ack();
        send_frame(8'h12, 1'b0);
        check_all("ferr_clear_12");
        ack();

        // Abort a frame with reset during bit 4.
        rb = 8'h81;
        u_bus.rx = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            u_bus.rx = rb[i];
            wait_cyc(BIT_CYC);
        end
        u_bus.rx = rb[4];
        wait_cyc(BIT_CYC / 2);
        rst = 1'b1;
        #1;
        m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_all("in_reset");
        wait_cyc(3);
        rst = 1'b0;
        u_bus.rx = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check_all("after_reset");
        send_frame(8'h81, 1'b0);
        check_all("post_reset_81");
        ack();

        tx_loopback(8'h55);
        check_all("loop_55");
        ack();
        tx_loopback(8'hC3);
        check_all("loop_c3");
        ack();
        tx_loopback(8'h7E);
        check_all("loop_7e");
        ack();

        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) == 0);
            send_frame(rb, rs);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                ack();
                check_all("rand_clr");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
